// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if: word-in / block-out handshake bundle for the AES block loader
interface aes_block_loader_if #(
  parameter int BUS_W = 32,
  parameter int WORDS = 4,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic                   in_sof;
  logic [BUS_W-1:0]       in_data;
  logic                   in_ready;
  logic                   blk_valid;
  logic                   blk_ready;
  logic [BUS_W*WORDS-1:0] blk_data;
  logic                   sync_err;
  logic [CNT_W-1:0]       blk_count;
  modport master (
    output in_valid, in_sof, in_data, blk_ready,
    input  in_ready, blk_valid, blk_data, sync_err, blk_count
  );
  modport slave (
    input  in_valid, in_sof, in_data, blk_ready,
    output in_ready, blk_valid, blk_data, sync_err, blk_count
  );
endinterface

// File: rtl/aes_block_loader.sv
// aes_block_loader: packs a 32-bit word stream into registered 128-bit blocks with resync and a handoff counter
module aes_block_loader #(
  parameter int BUS_W = 32,
  parameter int WORDS = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  aes_block_loader_if.slave bus
);
  localparam int BLK_W = BUS_W * WORDS;
  localparam int WC_W  = $clog2(WORDS);
  typedef enum logic {FILL, HOLD} state_t;
  state_t           state, state_n;
  logic [WC_W-1:0]  wcnt, wcnt_n;
  logic [BLK_W-1:0] sr, sr_n, data, data_n, shifted;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             valid, valid_n, err, err_n;
  logic             acc, resync, last, handoff;
  assign bus.in_ready  = !rst && state == FILL;
  assign bus.blk_valid = valid;
  assign bus.blk_data  = data;
  assign bus.sync_err  = err;
  assign bus.blk_count = cnt;
  assign acc     = bus.in_valid && bus.in_ready;
  assign shifted = {sr[BLK_W-BUS_W-1:0], bus.in_data};
  // an sof mid-block restarts framing, so it must never also complete a block
  assign resync  = acc && bus.in_sof && wcnt != '0;
  assign last    = acc && !resync && wcnt == WC_W'(WORDS - 1);
  assign handoff = state == HOLD && valid && bus.blk_ready;
  always_comb begin
    state_n = state == FILL ? (last ? HOLD : FILL) : (handoff ? FILL : HOLD);
    sr_n    = acc ? shifted : sr;
    wcnt_n  = last ? '0 : resync ? WC_W'(1) : acc ? wcnt + 1'b1 : wcnt;
    data_n  = last ? shifted : data;
    valid_n = last ? 1'b1 : handoff ? 1'b0 : valid;
    cnt_n   = handoff ? cnt + 1'b1 : cnt;
    err_n   = resync;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      wcnt  <= '0;
      sr    <= '0;
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      sr    <= sr_n;
      data  <= data_n;
      valid <= valid_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: scoreboard bench driving a 16-bit-counter and a 2-bit-counter loader in lockstep
module tb_aes_block_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [31:0] in_data = '0;
  logic        blk_ready = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;
  int          cnt_model = 0;
  int          sync_pulses = 0;
  logic [127:0] exp_q[$];
  always #5 clk = ~clk;
  aes_block_loader_if #(.CNT_W(16)) ia ();
  aes_block_loader_if #(.CNT_W(2))  ib ();
  assign ia.in_valid  = in_valid;
  assign ia.in_sof    = in_sof;
  assign ia.in_data   = in_data;
  assign ia.blk_ready = blk_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_sof    = in_sof;
  assign ib.in_data   = in_data;
  assign ib.blk_ready = blk_ready;
  aes_block_loader #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  aes_block_loader #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  // handoffs happen at the posedge after a negedge where valid & ready are both seen
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (ia.sync_err) sync_pulses++;
      if (ia.blk_valid && blk_ready) begin
        if (exp_q.size() == 0) check("sb_empty", 128'(exp_q.size()), 128'd1);
        else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          check("blk_data_a", ia.blk_data, e);
          check("blk_data_b", ib.blk_data, e);
          check("cnt_pre_a", ia.blk_count, 128'(cnt_model % 65536));
          check("cnt_pre_b", ib.blk_count, 128'(cnt_model % 4));
          cnt_model++;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_word(input logic [31:0] d, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    #1;
    while (!ia.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 128'(n), 128'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask
  task automatic push_block(input logic [127:0] blk, input int gap_max);
    exp_q.push_back(blk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle($urandom_range(gap_max, 0));
      push_word(blk[127-32*i -: 32], i == 0);
    end
    check("valid_lat", ia.blk_valid, 1);
    check("ready_hold", ia.in_ready, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cnt_model = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int p0;
    logic [127:0] hold_v;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", ia.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", ia.blk_valid, 0);
    check("rst_data", ia.blk_data, 0);
    check("rst_count", ia.blk_count, 0);
    check("rst_sync", ia.sync_err, 0);
    check("fill_ready", ia.in_ready, 1);
    // T1: FIPS-197 plaintext, back-to-back
    push_block(128'h3243f6a8885a308d313198a2e0370734, 0);
    @(negedge clk);
    check("t1_count", ia.blk_count, 1);
    check("t1_valid_drop", ia.blk_valid, 0);
    check("t1_ready_back", ia.in_ready, 1);
    // T2: downstream stall
    blk_ready = 1'b0;
    push_block(128'h00112233445566778899aabbccddeeff, 0);
    hold_v = ia.blk_data;
    for (int i = 0; i < 10; i++) begin
      check("t2_data_stable", ia.blk_data, 128'h00112233445566778899aabbccddeeff);
      check("t2_in_ready", ia.in_ready, 0);
      check("t2_valid", ia.blk_valid, 1);
      @(negedge clk);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    check("t2_ready_after", ia.in_ready, 1);
    check("t2_count", ia.blk_count, 2);
    check("t2_data_kept", ia.blk_data, hold_v);
    // T3: resync on a mid-block sof
    p0 = sync_pulses;
    push_word(32'h11111111, 1'b1);
    push_word(32'h22222222, 1'b0);
    exp_q.push_back(128'haaaaaaaa_00000000_00000000_00000000);
    push_word(32'haaaaaaaa, 1'b1);
    for (int i = 0; i < 3; i++) push_word(32'h0, 1'b0);
    check("t3_valid", ia.blk_valid, 1);
    @(negedge clk);
    #3;
    check("t3_sync_pulses", 128'(sync_pulses - p0), 128'd1);
    @(negedge clk);
    // T4: reset mid-fill drops partial words
    push_word(32'hdeadbeef, 1'b1);
    push_word(32'hcafef00d, 1'b0);
    push_word(32'h12345678, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    cnt_model = 0;
    #1;
    check("t4_in_ready_rst", ia.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4_valid", ia.blk_valid, 0);
    check("t4_data", ia.blk_data, 0);
    check("t4_count", ia.blk_count, 0);
    check("t4_sync", ia.sync_err, 0);
    @(negedge clk);
    push_block(128'h0, 0);
    @(negedge clk);
    check("t4_count_after", ia.blk_count, 1);
    // T5: gapped input
    do_reset();
    push_block(128'h0, 3);
    push_block(128'h1, 3);
    @(negedge clk);
    check("t5_count_a", ia.blk_count, 2);
    check("t5_count_b", ib.blk_count, 2);
    // T6: narrow counter wraps
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_block({$urandom, $urandom, $urandom, $urandom}, 1);
      @(negedge clk);
      check("t6_cnt_wrap", ib.blk_count, 128'((k + 1) % 4));
      check("t6_cnt_wide", ia.blk_count, 128'(k + 1));
    end
    idle(3);
    check("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
